// File: rtl/swd_multi_pkg.sv
// Shared definitions for the swd_multi switch/key input device:
// control register bit positions, default register offsets and the
// debounce counter width helper.
package swd_multi_pkg;

    // Control/status register bit positions
    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 1;
    localparam int CTRL_IE    = 8;

    // Default control register offset from the data register address
    localparam logic [31:0] DEF_CTRL_OFS = 32'h100;

    // Edge-capture register sits at BASE + EDGE_OFS_MULT * CTRL_OFS
    localparam int EDGE_OFS_MULT = 2;

    // Debounce counter width; wide enough to hold DEB_SAMPLES-1 with headroom
    function automatic int cnt_width(input int samples);
        return $clog2(samples) + 1;
    endfunction

endpackage

// File: rtl/swd_debounce_chan.sv
// One input channel: 2-flop synchroniser, debounce counter, accepted data
// bit and a one-cycle change pulse. The counter advances only on the shared
// prescaler tick; a change is accepted after DEB_SAMPLES consecutive ticks
// in which the synchronised sample differs from the accepted data bit.
module swd_debounce_chan
    import swd_multi_pkg::*;
#(
    parameter int DEB_SAMPLES = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    input  logic tick_i,
    output logic data_o,
    output logic change_o
);

    localparam int CW = cnt_width(DEB_SAMPLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          data_q;
    logic          data_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          change;

    // Two-stage synchroniser for the raw asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce decision, evaluated only on a prescaler tick
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        change = 1'b0;
        if (tick_i) begin
            if (sync2_q == data_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_SAMPLES - 1)) begin
                data_d = sync2_q;
                cnt_d  = '0;
                change = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Accepted data bit and debounce counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o   = data_q;
    assign change_o = change;

endmodule

// File: rtl/swd_multi.sv
// Memory-mapped multi-channel switch/key input device.
// Data register at BASE (read-only), control/status register at
// BASE+CTRL_OFS (Ready, Overrun, IE), level interrupt INTR = IE & Ready,
// registered. Optional edge-capture register at BASE+2*CTRL_OFS is built
// when the macro SWD_MULTI_EDGE_CAP_EN is defined.
//
// Bus handshake: a single-cycle access. When ABUS matches a register and
// WE=1, the write takes effect at the next posedge CLK. When WE=0 the
// selected register is driven combinationally onto DBUS for as long as the
// selection holds; a data read clears Ready at the posedge it spans. DBUS
// is high-Z whenever no register is selected for reading.
module swd_multi
    import swd_multi_pkg::*;
#(
    parameter int              BITS        = 32,
    parameter logic [BITS-1:0] BASE        = BITS'('hF0000010),
    parameter logic [BITS-1:0] CTRL_OFS    = BITS'(DEF_CTRL_OFS),
    parameter int              NCH         = 10,
    parameter int              DEB_TICKS   = 5000,
    parameter int              DEB_SAMPLES = 10
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic [NCH-1:0]  IN,
    output logic            INTR
);

    localparam int              PW        = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [BITS-1:0] CTRL_ADDR = BASE + CTRL_OFS;

    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            tick;
    logic [NCH-1:0]  data;
    logic [NCH-1:0]  change;
    logic            any_change;
    logic            sel_data;
    logic            sel_ctrl;
    logic            rd_data;
    logic            wr_ctrl;
    logic            ready_q;
    logic            ready_d;
    logic            ovr_q;
    logic            ovr_d;
    logic            ie_q;
    logic            ie_d;
    logic            irq_src;
    logic            intr_q;
    logic            intr_d;
    logic            drive;
    logic [BITS-1:0] rd_val;
    logic            unused_dbus;

    // Debounce sample-rate prescaler; tick on the last count then wrap
    always_comb begin
        tick    = (presc_q == PW'(DEB_TICKS - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Prescaler register
    always_ff @(posedge CLK) begin
        if (RESET) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            swd_debounce_chan #(
                .DEB_SAMPLES(DEB_SAMPLES)
            ) u_chan (
                .clk_i   (CLK),
                .rst_i   (RESET),
                .in_i    (IN[g]),
                .tick_i  (tick),
                .data_o  (data[g]),
                .change_o(change[g])
            );
        end
    endgenerate

    assign any_change = |change;
    assign sel_data   = (ABUS == BASE);
    assign sel_ctrl   = (ABUS == CTRL_ADDR);
    assign rd_data    = sel_data & ~WE;
    assign wr_ctrl    = sel_ctrl & WE;

    // Control register next state; a channel change wins over a clear
    always_comb begin
        ready_d = ready_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        if (wr_ctrl) begin
            ie_d = DBUS[CTRL_IE];
            if (!DBUS[CTRL_OVR]) ovr_d = 1'b0;
        end
        if (rd_data) ready_d = 1'b0;
        if (any_change) begin
            ready_d = 1'b1;
            // A read consuming the old value in the same cycle loses nothing
            if (ready_q && !rd_data) ovr_d = 1'b1;
        end
    end

    // Control register state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

`ifdef SWD_MULTI_EDGE_CAP_EN
    localparam logic [BITS-1:0] EDGE_ADDR = BASE + CTRL_OFS * BITS'(EDGE_OFS_MULT);

    logic           sel_edge;
    logic           wr_edge;
    logic [NCH-1:0] ecap_q;
    logic [NCH-1:0] ecap_d;

    assign sel_edge = (ABUS == EDGE_ADDR);
    assign wr_edge  = sel_edge & WE;

    // Edge capture: write-1-to-clear, a new change on the same bit wins
    always_comb begin
        ecap_d = ecap_q;
        if (wr_edge) ecap_d = ecap_d & ~DBUS[NCH-1:0];
        ecap_d = ecap_d | change;
    end

    // Edge-capture register
    always_ff @(posedge CLK) begin
        if (RESET) ecap_q <= '0;
        else       ecap_q <= ecap_d;
    end

    assign irq_src = ready_q | (|ecap_q);
`else
    assign irq_src = ready_q;
`endif

    assign intr_d = ie_q & irq_src;

    // Registered level interrupt
    always_ff @(posedge CLK) begin
        if (RESET) intr_q <= 1'b0;
        else       intr_q <= intr_d;
    end

    assign INTR = intr_q;

    // Read mux: zero-extended register contents for the selected address
    always_comb begin
        rd_val = '0;
        drive  = 1'b0;
        if (!WE) begin
            if (sel_data) begin
                drive             = 1'b1;
                rd_val[NCH-1:0]   = data;
            end else if (sel_ctrl) begin
                drive              = 1'b1;
                rd_val[CTRL_READY] = ready_q;
                rd_val[CTRL_OVR]   = ovr_q;
                rd_val[CTRL_IE]    = ie_q;
            end
`ifdef SWD_MULTI_EDGE_CAP_EN
            else if (sel_edge) begin
                drive           = 1'b1;
                rd_val[NCH-1:0] = ecap_q;
            end
`endif
        end
    end

    assign DBUS = drive ? rd_val : {BITS{1'bz}};

    // Only a few DBUS bits are consumed on writes
    assign unused_dbus = ^DBUS;

endmodule

// File: tb/tb_swd_multi.sv
// Directed bench for swd_multi with DEB_TICKS=4, DEB_SAMPLES=3, NCH=4,
// BASE='h100, CTRL_OFS='h100. Define SWD_MULTI_EDGE_CAP_EN to include the
// edge-capture steps.
module tb_swd_multi;

    localparam int          NCH    = 4;
    localparam logic [31:0] A_DATA = 32'h100;
    localparam logic [31:0] A_CTRL = 32'h200;
    localparam logic [31:0] A_EDGE = 32'h300;
    localparam logic [31:0] A_IDLE = 32'h0;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    abus;
    logic           we;
    logic [NCH-1:0] in_v;
    wire            intr;
    wire  [31:0]    dbus;
    logic [31:0]    drv_val;
    logic           drv_en;

    int             checks = 0;
    int             errors = 0;
    logic [31:0]    exp_q[$];
    string          tag_q[$];
    logic [NCH-1:0] cur_in;

    assign dbus = drv_en ? drv_val : {32{1'bz}};

    swd_multi #(
        .BITS(32), .BASE(32'h100), .CTRL_OFS(32'h100),
        .NCH(NCH), .DEB_TICKS(4), .DEB_SAMPLES(3)
    ) dut (
        .CLK(clk), .RESET(rst), .ABUS(abus), .DBUS(dbus),
        .WE(we), .IN(in_v), .INTR(intr)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start just after a negedge and return just after the
    // next negedge, so each access spans exactly one posedge.
    task automatic idle();
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] pre, output logic [31:0] post);
        abus = addr; we = 1'b0; drv_en = 1'b0;
        #1 pre = dbus;
        @(posedge clk);
        #1 post = dbus;
        @(negedge clk);
        abus = A_IDLE;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input string tag);
        abus = addr; we = 1'b1; drv_val = val; drv_en = 1'b1;
        #1 check(tag, dbus, val);
        @(negedge clk);
        we = 1'b0; drv_en = 1'b0; abus = A_IDLE;
    endtask

    // Scoreboard read: expectation queued with the stimulus, popped on the response
    task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] pre;
        logic [31:0] post;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_read(addr, pre, post);
        check(tag_q.pop_front(), pre, exp_q.pop_front());
    endtask

    task automatic poll_read(input logic [31:0] addr, input logic [31:0] mask, input string tag);
        logic        found;
        logic [31:0] pre;
        logic [31:0] post;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            bus_read(addr, pre, post);
            if ((pre & mask) != 0) found = 1'b1;
        end
        check(tag, {31'b0, found}, 32'd1);
    endtask

    // Reset, then debounce v in from a zero data register: accepted on the
    // 12th posedge after reset release (ticks at posedges 4, 8, 12).
    task automatic reset_debounce(input logic [NCH-1:0] v);
        rst = 1'b1; in_v = v;
        @(negedge clk);
        rd_check(A_DATA, 32'h0, "rst_data");
        rd_check(A_CTRL, 32'h0, "rst_ctrl");
        check("rst_intr", {31'b0, intr}, 32'h0);
        rst = 1'b0;
        for (int j = 1; j <= 12; j++) rd_check(A_DATA, 32'h0, "deb_wait");
        rd_check(A_CTRL, 32'h001, "deb_ready_read_collide");
        rd_check(A_DATA, {28'b0, v}, "deb_data");
        rd_check(A_CTRL, 32'h000, "deb_ready_clr");
    endtask

    initial begin : stim
        logic        found;
        logic        intr_s;
        logic [31:0] pre;
        logic [31:0] post;

        rst = 1'b1; abus = A_IDLE; we = 1'b0; in_v = '0; drv_val = '0; drv_en = 1'b0;
        @(negedge clk);

        // Reset, then 0101 debounces in
        reset_debounce(4'b0101);

        // Bounce on IN[0] every 5 cycles never reaches 3 consecutive ticks
        for (int k = 0; k < 8; k++) begin
            in_v[0] = k[0];
            repeat (4) idle();
            rd_check(A_CTRL, 32'h0, "bounce_ctrl");
        end
        repeat (8) idle();
        rd_check(A_CTRL, 32'h0, "bounce_ctrl_end");
        rd_check(A_DATA, 32'h5, "bounce_data");

        // Two accepted changes without a read -> Overrun
        in_v = 4'b0111;
        poll_read(A_CTRL, 32'h1, "ovr_first_change");
        rd_check(A_CTRL, 32'h001, "ovr_ready");
        in_v = 4'b1111;
        poll_read(A_CTRL, 32'h2, "ovr_second_change");
        rd_check(A_CTRL, 32'h003, "ovr_set");
        bus_write(A_CTRL, 32'h000, "wr_ctrl_bus");
        rd_check(A_CTRL, 32'h001, "ovr_cleared");
        rd_check(A_DATA, 32'hF, "ovr_data");
        rd_check(A_CTRL, 32'h000, "ovr_ready_clr");

        // Interrupt enable and registered INTR
        bus_write(A_CTRL, 32'h100, "wr_ie_bus");
        rd_check(A_CTRL, 32'h100, "ie_set");
        check("intr_idle", {31'b0, intr}, 32'h0);
        in_v = 4'b1011;
        found = 1'b0;
        intr_s = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            intr_s = intr;
            bus_read(A_CTRL, pre, post);
            if (pre[0]) found = 1'b1;
        end
        check("intr_poll", {31'b0, found}, 32'd1);
        check("intr_lag", {31'b0, intr_s}, 32'h0);
        check("intr_rise", {31'b0, intr}, 32'h1);
        rd_check(A_CTRL, 32'h101, "ie_ready");
        rd_check(A_DATA, 32'hB, "intr_data");
        check("intr_hold", {31'b0, intr}, 32'h1);
        idle();
        check("intr_fall", {31'b0, intr}, 32'h0);
        rd_check(A_CTRL, 32'h100, "ie_kept");

        // Change accepted in the same cycle as a data read
        bus_write(A_CTRL, 32'h000, "wr_ie_clr_bus");
        in_v = 4'b1111;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            bus_read(A_DATA, pre, post);
            if (pre != post) found = 1'b1;
        end
        check("collide_poll", {31'b0, found}, 32'd1);
        check("collide_new_data", post, 32'hF);
        rd_check(A_CTRL, 32'h001, "collide_ctrl");
        rd_check(A_DATA, 32'hF, "collide_data");
        rd_check(A_CTRL, 32'h000, "collide_ctrl_clr");

        // Writes to the data register are ignored
        bus_write(A_DATA, 32'h0, "wr_data_bus");
        rd_check(A_DATA, 32'hF, "wr_data_ignored");
        rd_check(A_CTRL, 32'h000, "wr_data_ctrl");
        cur_in = 4'b1111;

`ifdef SWD_MULTI_EDGE_CAP_EN
        bus_write(A_EDGE, 32'hF, "wr_edge_all_bus");
        rd_check(A_EDGE, 32'h0, "edge_cleared");
        in_v = 4'b1011;
        cur_in = 4'b1011;
        poll_read(A_EDGE, 32'hF, "edge_poll");
        rd_check(A_EDGE, 32'h4, "edge_ch2");
        bus_write(A_EDGE, 32'h4, "wr_edge_bus");
        rd_check(A_EDGE, 32'h0, "edge_w1c");
        bus_write(A_DATA, 32'hF, "wr_data_f_bus");
        rd_check(A_DATA, 32'hB, "edge_data_unchanged");
        rd_check(A_CTRL, 32'h000, "edge_ctrl");
`endif

        // Reset in the middle of a debounce discards partial counts
        cur_in = cur_in ^ 4'b0001;
        in_v = cur_in;
        repeat (6) idle();
        reset_debounce(cur_in);
`ifdef SWD_MULTI_EDGE_CAP_EN
        rd_check(A_EDGE, {28'b0, cur_in}, "edge_after_reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
